// File: rtl/modarith_pkg.sv
// Shared types for the modular-arithmetic engine: opcodes,
// FSM states, error codes and Montgomery sequencing phases.
package modarith_pkg;

    typedef enum logic [2:0] {
        OP_ADD    = 3'b000,
        OP_SUB    = 3'b001,
        OP_MOD    = 3'b010,
        OP_RSETUP = 3'b011,
        OP_MULT   = 3'b100,
        OP_EXP    = 3'b101
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ADDSUB,
        MODRED,
        RSET,
        MM_RUN,
        EXP_SEL,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        ERR_OK    = 2'b00,
        ERR_MOD   = 2'b01,
        ERR_RANGE = 2'b10,
        ERR_OP    = 2'b11
    } err_e;

    // Which Montgomery product the sequencer issues next.
    typedef enum logic [2:0] {
        PH_AM,
        PH_SQR,
        PH_MUL,
        PH_ONE,
        PH_AB,
        PH_R2
    } ph_e;

endpackage

// File: rtl/modarith_if.sv
// Request/response bundle of the engine.
// master: drives start/op/a/b/modulant; slave: returns busy/done/result/err/cache.
interface modarith_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic [2:0]            op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH-1:0] modulant;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;
    logic [1:0]            err;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_mod;
    logic [DATA_WIDTH-1:0] r_sqr;

    modport master (
        output start, op, a, b, modulant,
        input  busy, done, result, err,
        input  r_valid, r_mod, r_sqr
    );

    modport slave (
        input  start, op, a, b, modulant,
        output busy, done, result, err,
        output r_valid, r_mod, r_sqr
    );
endinterface

// File: rtl/mont_mul_serial.sv
// Radix-2 serial Montgomery multiplier: p = x*y*2^-W mod m.
// Ports: clk, reset, start (taken when idle), x, y, m -> busy, done pulse, p.
module mont_mul_serial #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] x,
    input  logic [DATA_WIDTH-1:0] y,
    input  logic [DATA_WIDTH-1:0] m,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] p
);
    localparam int W  = DATA_WIDTH;
    localparam int AW = W + 2;
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  xs, ys, ms;
    logic [AW-1:0] acc, s1, s2;
    logic [CW-1:0] cnt;

    // acc stays below 2m, so acc + y + m fits in W+2 bits.
    always_comb begin
        s1 = acc + (xs[0] ? {2'b00, ys} : '0);
        s2 = s1 + (s1[0] ? {2'b00, ms} : '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xs   <= '0;
            ys   <= '0;
            ms   <= '0;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            p    <= '0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    xs   <= x;
                    ys   <= y;
                    ms   <= m;
                    acc  <= '0;
                    cnt  <= '0;
                    busy <= 1'b1;
                end
            end else if (cnt == CW'(W)) begin
                p    <= (acc >= {2'b00, ms}) ? W'(acc - {2'b00, ms})
                                             : acc[W-1:0];
                busy <= 1'b0;
                done <= 1'b1;
            end else begin
                acc <= s2 >> 1;
                xs  <= xs >> 1;
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/modarith_engine.sv
// Sequential modular-arithmetic engine with cached Montgomery constants.
// Ports: clk, reset, bus (modarith_if.slave). Option: MODARITH_AUTO_RSETUP_EN.
module modarith_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = $clog2(2*DATA_WIDTH+1)
) (
    input logic       clk,
    input logic       reset,
    modarith_if.slave bus
);
    import modarith_pkg::*;

    localparam int W = DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST_W  = CNT_WIDTH'(W - 1);
    localparam logic [CNT_WIDTH-1:0] LAST_2W = CNT_WIDTH'(2*W - 1);

    state_e st, nxt;
    ph_e    ph;
    err_e   err_q, ck_err;

    logic [2:0]           op_q;
    logic [W-1:0]         a_q, b_q, m_q;
    logic [W-1:0]         rem, tmp_r, acc, am, bsh;
    logic [W-1:0]         cache_m, r_mod_q, r_sqr_q, result_q;
    logic [2*W-1:0]       sh;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 r_valid_q;

    logic         mm_go, mm_busy, mm_done;
    logic [W-1:0] mm_x, mm_y, mm_p;

    logic [W:0]   m_ext, sum_ext, dif_ext, rem_sh;
    logic [W-1:0] add_res, sub_res, rem_nxt;
    logic         needs_r, stale;

    mont_mul_serial #(.DATA_WIDTH(W)) u_mm (
        .clk   (clk),
        .reset (reset),
        .start (mm_go),
        .x     (mm_x),
        .y     (mm_y),
        .m     (m_q),
        .busy  (mm_busy),
        .done  (mm_done),
        .p     (mm_p)
    );

    // One reducer serves both mod (shift in dividend bits) and
    // rsetup (shift in zero, i.e. x = 2x mod m).
    always_comb begin
        m_ext   = {1'b0, m_q};
        sum_ext = {1'b0, a_q} + {1'b0, b_q};
        dif_ext = {1'b0, a_q} - {1'b0, b_q};
        add_res = (sum_ext >= m_ext) ? W'(sum_ext - m_ext)
                                     : sum_ext[W-1:0];
        sub_res = dif_ext[W] ? W'(dif_ext + m_ext)
                             : dif_ext[W-1:0];
        rem_sh  = {rem, (op_q == OP_MOD) ? sh[2*W-1] : 1'b0};
        rem_nxt = (rem_sh >= m_ext) ? W'(rem_sh - m_ext)
                                    : rem_sh[W-1:0];
    end

    always_comb begin
        needs_r = (op_q == OP_MULT) || (op_q == OP_EXP);
        stale   = !r_valid_q || (cache_m != m_q);
        ck_err  = ERR_OK;
        if (m_q < W'(2) ||
            ((needs_r || op_q == OP_RSETUP) && !m_q[0]))
            ck_err = ERR_MOD;
        else if (op_q > OP_EXP)
            ck_err = ERR_OP;
        else if (((op_q == OP_ADD || op_q == OP_SUB ||
                   op_q == OP_MULT) &&
                  (a_q >= m_q || b_q >= m_q)) ||
                 (op_q == OP_EXP && a_q >= m_q))
            ck_err = ERR_RANGE;
        else if (needs_r && stale) begin
`ifdef MODARITH_AUTO_RSETUP_EN
            ck_err = ERR_OK;
`else
            ck_err = ERR_OP;
`endif
        end
    end

    always_comb begin
        nxt   = st;
        mm_go = 1'b0;
        mm_x  = acc;
        mm_y  = acc;
        unique case (st)
            IDLE:    if (bus.start) nxt = CHECK;
            CHECK: begin
                if (ck_err != ERR_OK)
                    nxt = DONE;
                else if (op_q == OP_ADD || op_q == OP_SUB)
                    nxt = ADDSUB;
                else if (op_q == OP_MOD)
                    nxt = MODRED;
                else if (op_q == OP_RSETUP || stale)
                    nxt = RSET;
                else
                    nxt = EXP_SEL;
            end
            ADDSUB:  nxt = DONE;
            MODRED:  if (cnt == LAST_2W) nxt = DONE;
            // An implicit rsetup re-enters CHECK with the fresh cache.
            RSET:    if (cnt == LAST_2W)
                         nxt = (op_q == OP_RSETUP) ? DONE : CHECK;
            EXP_SEL: if (!mm_busy) begin
                mm_go = 1'b1;
                nxt   = MM_RUN;
                unique case (ph)
                    PH_AM:  begin mm_x = a_q; mm_y = r_sqr_q; end
                    PH_MUL: mm_y = am;
                    PH_ONE: mm_y = W'(1);
                    PH_AB:  begin mm_x = a_q; mm_y = b_q; end
                    PH_R2:  mm_y = r_sqr_q;
                    default: ;
                endcase
            end
            MM_RUN:  if (mm_done)
                         nxt = (ph == PH_ONE || ph == PH_R2) ? DONE
                                                             : EXP_SEL;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) st <= IDLE;
        else       st <= nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            m_q       <= '0;
            rem       <= '0;
            tmp_r     <= '0;
            acc       <= '0;
            am        <= '0;
            bsh       <= '0;
            sh        <= '0;
            cnt       <= '0;
            ph        <= PH_AM;
            err_q     <= ERR_OK;
            result_q  <= '0;
            cache_m   <= '0;
            r_mod_q   <= '0;
            r_sqr_q   <= '0;
            r_valid_q <= 1'b0;
        end else begin
            unique case (st)
                IDLE: if (bus.start) begin
                    op_q <= bus.op;
                    a_q  <= bus.a;
                    b_q  <= bus.b;
                    m_q  <= bus.modulant;
                end
                CHECK: if (ck_err != ERR_OK) begin
                    result_q <= '0;
                    err_q    <= ck_err;
                end else begin
                    err_q <= ERR_OK;
                    cnt   <= '0;
                    sh    <= {a_q, b_q};
                    bsh   <= b_q;
                    rem   <= (op_q == OP_MOD) ? '0 : W'(1);
                    ph    <= (op_q == OP_MULT) ? PH_AB : PH_AM;
                end
                ADDSUB:
                    result_q <= (op_q == OP_ADD) ? add_res : sub_res;
                MODRED, RSET: begin
                    rem <= rem_nxt;
                    sh  <= sh << 1;
                    cnt <= cnt + 1'b1;
                    if (st == RSET && cnt == LAST_W)
                        tmp_r <= rem_nxt;
                    if (cnt == LAST_2W) begin
                        if (st == MODRED) begin
                            result_q <= rem_nxt;
                        end else begin
                            cache_m   <= m_q;
                            r_valid_q <= 1'b1;
                            r_mod_q   <= tmp_r;
                            r_sqr_q   <= rem_nxt;
                            if (op_q == OP_RSETUP)
                                result_q <= tmp_r;
                        end
                    end
                end
                // cnt counts exponent bits still to square; bsh[W-1]
                // is the current bit.
                MM_RUN: if (mm_done) begin
                    unique case (ph)
                        PH_AM: begin
                            am  <= mm_p;
                            acc <= r_mod_q;
                            cnt <= LAST_W;
                            ph  <= PH_SQR;
                        end
                        PH_SQR: begin
                            acc <= mm_p;
                            if (bsh[W-1]) begin
                                ph <= PH_MUL;
                            end else if (cnt == '0) begin
                                ph <= PH_ONE;
                            end else begin
                                cnt <= cnt - 1'b1;
                                bsh <= bsh << 1;
                            end
                        end
                        PH_MUL: begin
                            acc <= mm_p;
                            if (cnt == '0) begin
                                ph <= PH_ONE;
                            end else begin
                                cnt <= cnt - 1'b1;
                                bsh <= bsh << 1;
                                ph  <= PH_SQR;
                            end
                        end
                        PH_AB: begin
                            acc <= mm_p;
                            ph  <= PH_R2;
                        end
                        default: result_q <= mm_p;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (st != IDLE) && (st != DONE);
    assign bus.done    = (st == DONE);
    assign bus.result  = result_q;
    assign bus.err     = err_q;
    assign bus.r_valid = r_valid_q;
    assign bus.r_mod   = r_mod_q;
    assign bus.r_sqr   = r_sqr_q;
endmodule

// File: tb/tb_modarith_engine.sv
// Self-checking bench for modarith_engine (W=8) with a result scoreboard.
// Follows MODARITH_AUTO_RSETUP_EN when defined.
module tb_modarith_engine;

    localparam int W = 8;

    typedef struct {
        string      tag;
        logic [7:0] res;
        logic [1:0] err;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    modarith_if #(.DATA_WIDTH(W)) bus ();

    modarith_engine #(.DATA_WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, got, want);
        end
    endtask

    function automatic int model(int o, int x, int y, int m);
        int r, base;
        case (o)
            0: return (x + y) % m;
            1: return (x - y + m) % m;
            4: return (x * y) % m;
            default: begin
                r = 1;
                base = x % m;
                for (int i = 0; i < W; i++) begin
                    if (y[i]) r = (r * base) % m;
                    base = (base * base) % m;
                end
                return r;
            end
        endcase
    endfunction

    // Issue one op; lat=0 skips the latency check. poke re-pulses
    // start mid-operation, which must have no effect.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [7:0] xa, input logic [7:0] xb,
                          input logic [7:0] xm, input logic [7:0] er,
                          input logic [1:0] ee, input int lat,
                          input bit poke);
        exp_t e;
        int   cyc;
        bit   seen;
        e.tag = tag;
        e.res = er;
        e.err = ee;
        e.lat = lat;
        sb.push_back(e);
        @(negedge clk);
        bus.op       = o;
        bus.a        = xa;
        bus.b        = xb;
        bus.modulant = xm;
        bus.start    = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 2)
                check({tag, ".busy"}, 32'(bus.busy), 1);
            bus.start = poke && (cyc == 3);
            if (poke && cyc == 3) begin
                bus.op = 3'b000;
                bus.a  = 8'd1;
                bus.b  = 8'd1;
            end
            if (bus.done) seen = 1'b1;
        end
        bus.start = 1'b0;
        e = sb.pop_front();
        if (!seen) begin
            check({e.tag, ".timeout"}, 0, 1);
        end else begin
            check({e.tag, ".res"}, 32'(bus.result), 32'(e.res));
            check({e.tag, ".err"}, 32'(bus.err), 32'(e.err));
            if (e.lat > 0)
                check({e.tag, ".lat"}, cyc, e.lat);
        end
    endtask

    initial begin
        int o, x, y, want;
        bus.start    = 1'b0;
        bus.op       = '0;
        bus.a        = '0;
        bus.b        = '0;
        bus.modulant = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.busy", 32'(bus.busy), 0);
        check("rst.done", 32'(bus.done), 0);
        check("rst.result", 32'(bus.result), 0);
        check("rst.rvalid", 32'(bus.r_valid), 0);
        check("rst.rmod", 32'(bus.r_mod), 0);
        reset = 1'b0;

        run_op("add", 3'b000, 8'd7, 8'd9, 8'd13, 8'd3, 2'b00, 3, 0);
        run_op("sub", 3'b001, 8'd3, 8'd9, 8'd13, 8'd7, 2'b00, 3, 0);
        run_op("mod", 3'b010, 8'h01, 8'h02, 8'd13, 8'd11, 2'b00, 18, 0);
        run_op("mod_m0", 3'b010, 8'h01, 8'h02, 8'd0, 8'd0, 2'b01, 2, 0);
        run_op("add_rng", 3'b000, 8'd13, 8'd1, 8'd13, 8'd0, 2'b10, 2, 0);
        run_op("ill_op", 3'b110, 8'd1, 8'd1, 8'd13, 8'd0, 2'b11, 2, 0);

        run_op("rsetup", 3'b011, 8'd0, 8'd0, 8'd13, 8'd9, 2'b00, 18, 0);
        check("rsetup.rmod", 32'(bus.r_mod), 9);
        check("rsetup.rsqr", 32'(bus.r_sqr), 3);
        check("rsetup.rvalid", 32'(bus.r_valid), 1);

        run_op("rset_bad", 3'b011, 8'd0, 8'd0, 8'd12, 8'd0, 2'b01, 2, 0);
        check("rset_bad.rmod", 32'(bus.r_mod), 9);
        check("rset_bad.rvalid", 32'(bus.r_valid), 1);

        run_op("mult", 3'b100, 8'd7, 8'd9, 8'd13, 8'd11, 2'b00, 0, 0);
        run_op("exp", 3'b101, 8'd2, 8'd10, 8'd13, 8'd10, 2'b00, 0, 0);
        run_op("exp_b0", 3'b101, 8'd5, 8'd0, 8'd13, 8'd1, 2'b00, 0, 0);
        run_op("exp_rng", 3'b101, 8'd13, 8'd3, 8'd13, 8'd0, 2'b10, 2, 0);

`ifdef MODARITH_AUTO_RSETUP_EN
        run_op("mult_m11", 3'b100, 8'd7, 8'd9, 8'd11, 8'd8, 2'b00, 0, 0);
        check("mult_m11.rmod", 32'(bus.r_mod), 3);
`else
        run_op("mult_m11", 3'b100, 8'd7, 8'd9, 8'd11, 8'd0, 2'b11, 2, 0);
        check("mult_m11.rmod", 32'(bus.r_mod), 9);
`endif
        run_op("mult_m12", 3'b100, 8'd7, 8'd9, 8'd12, 8'd0, 2'b01, 2, 0);
        run_op("rsetup2", 3'b011, 8'd0, 8'd0, 8'd13, 8'd9, 2'b00, 18, 0);

        run_op("exp_poke", 3'b101, 8'd2, 8'd10, 8'd13, 8'd10, 2'b00, 0, 1);
        @(negedge clk);
        check("poke.idle", 32'(bus.busy), 0);

        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 3))
                0: o = 0;
                1: o = 1;
                2: o = 4;
                default: o = 5;
            endcase
            x = $urandom_range(0, 12);
            y = (o == 5) ? $urandom_range(0, 255) : $urandom_range(0, 12);
            want = model(o, x, y, 13);
            run_op($sformatf("rnd%0d", i), 3'(o), 8'(x), 8'(y), 8'd13,
                   8'(want), 2'b00, 0, 0);
        end

        run_op("exp_pre", 3'b101, 8'd3, 8'd5, 8'd13, 8'd9, 2'b00, 0, 0);
        @(negedge clk);
        bus.op       = 3'b101;
        bus.a        = 8'd2;
        bus.b        = 8'd255;
        bus.modulant = 8'd13;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid.busy", 32'(bus.busy), 0);
        check("rst_mid.rvalid", 32'(bus.r_valid), 0);
        check("rst_mid.result", 32'(bus.result), 0);
        check("rst_mid.done", 32'(bus.done), 0);
        @(negedge clk);
        reset = 1'b0;

`ifdef MODARITH_AUTO_RSETUP_EN
        run_op("post_rst", 3'b100, 8'd7, 8'd9, 8'd13, 8'd11, 2'b00, 0, 0);
`else
        run_op("post_rst", 3'b100, 8'd7, 8'd9, 8'd13, 8'd0, 2'b11, 2, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/modarith_engine.md
Name: modarith_engine

Overview:
- Parametrised, fully sequential modular-arithmetic engine for RSA-style software offload.
- Supports add, sub, 2W-bit reduction, Montgomery constant setup, modular multiply and modular exponentiation at any DATA_WIDTH.
- Operands are registered; one start/busy/done handshake; Montgomery constants cached internally and tagged with their modulus.
- Sits between the CPU memory-mapped register bank and the arithmetic datapath.

Parameters:
- DATA_WIDTH, 8, operand/modulus width W (>=4).
- CNT_WIDTH, $clog2(2*DATA_WIDTH+1), width of the iteration counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  3  000 add, 001 sub, 010 mod, 011 rsetup, 100 mult, 101 exp, others illegal
- a  in  W  operand A / base / high word for mod
- b  in  W  operand B / exponent / low word for mod
- modulant  in  W  modulus m
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse; result and err valid in that cycle and held until next start
- result  out  W  registered result
- err  out  2  00 ok, 01 bad modulus, 10 operand out of range, 11 illegal op or stale R
- r_valid  out  1  cached R mod m and R^2 mod m are valid for cached modulus
- r_mod  out  W  R mod m, with R = 2^W
- r_sqr  out  W  R^2 mod m

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; cached modulus 0; r_valid 0.
- Reset mid-operation: immediate abort to IDLE; cache invalidated.
- Start handling:
  - start in IDLE: latch a, b, modulant and op.
  - start while busy: ignored, with no effect.
- FSM states: IDLE, CHECK, ADDSUB, MODRED, RSET, MM_RUN, EXP_SEL, DONE.
- CHECK (1 cycle) fails to DONE with result=0 on any of:
  - Any op with m<2: err=01.
  - rsetup/mult/exp with m even: err=01.
  - add/sub/mult with a>=m or b>=m: err=10.
  - exp with a>=m: err=10.
  - Illegal op: err=11.
  - mult/exp with r_valid=0 or m != cached modulus: err=11.
- Add/sub:
  - Computed in W+1 bits, with one conditional correction by m.
  - Latency: done 3 cycles after start edge (CHECK, ADDSUB, DONE).
- Mod:
  - Input is {a,b} (2W bits) reduced mod m by restoring shift-subtract.
  - 2W iterations; done at 2W+2 cycles after start.
- Rsetup:
  - x=1; repeat 2W times: x = 2x mod m.
  - Capture r_mod after iteration W; r_sqr after iteration 2W.
  - Then: cached modulus=m, r_valid=1, result=r_mod, done.
  - A failed rsetup leaves the existing cache untouched.
- MontMul(x,y) = x*y*R^-1 mod m:
  - Radix-2 serial, W iterations plus final conditional subtract = W+1 cycles.
  - Accumulator is W+2 bits.
- Mult:
  - t=MontMul(a,b), then result=MontMul(t,r_sqr).
- Exp (left-to-right square-and-multiply):
  - aM=MontMul(a,r_sqr); acc=r_mod.
  - For each bit of b, MSB first: acc=MontMul(acc,acc); if bit set, acc=MontMul(acc,aM).
  - result=MontMul(acc,1).
  - Number of MontMuls = W+2+popcount(b).
  - b=0 gives result 1.
- DONE: 1 cycle; done=1, busy=0; return to IDLE. A start in the same cycle is not accepted.

Optional Feature:
- Macro MODARITH_AUTO_RSETUP_EN.
- Defined: mult/exp with stale or missing cache and odd m>=2 runs an rsetup first, updates the cache, then continues the op with no error; latency grows by 2W+1.
- Undefined: the stale/missing cache case reports err=11 as above.

Decomposition:
- Package modarith_pkg: op_e enum (OP_ADD..OP_EXP), state_e enum, err_e constants.
- Sub-module mont_mul_serial:
  - Parametrised by DATA_WIDTH.
  - Ports: clk, reset, start, x, y, m; outputs busy, done, p.
  - Instantiated once and sequenced by the top FSM.

Test Plan:
- W=8, m=13, a=7, b=9, add -> result 3, err 00, done 3 cycles after start; sub (a=3, b=9) -> result 7.
- mod, a=0x01, b=0x02, m=13 -> result 11 (258 mod 13), done at cycle 18; m=0 -> err 01.
- rsetup, m=13 -> r_mod 9, r_sqr 3, r_valid 1, result 9.
- After rsetup: mult 7*9 -> 11. exp a=2, b=10 -> 10. exp b=0 -> 1.
- mult with m=11 after rsetup on 13 -> err 11 (macro off) or result 8 with r_mod 3 (macro on). mult with m=12 -> err 01.
- Reset asserted mid-exp -> busy 0, r_valid 0, result 0 next cycle. start pulsed while busy -> ignored, original result unchanged.
